// File: rtl/kernel_kcore_arb_pkg.sv
// Shared types and helpers for the kcore start arbiter.
package kernel_kcore_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/kernel_kcore_rr_pick.sv
// Round-robin picker: rotate the request vector past the last grant and
// priority-encode the first set bit.
module kernel_kcore_rr_pick
  import kernel_kcore_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]  onehot,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  logic                found;
  logic [ID_WIDTH-1:0] pos;

  // Scan last+1 .. last (wrapping); the first requesting position wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      pos = ID_WIDTH'((32'(last) + off) % NUM_REQ);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/kernel_kcore_start_arbiter.sv
// Shares one ap_ctrl_chain process between NUM_REQ start FIFOs.
// Round-robin pops one token, issues ap_start with grant id/token, then
// waits for ap_done before the next grant.
// Optional per-requester grant counters: define KCORE_ARB_PERF_EN.
module kernel_kcore_start_arbiter
  import kernel_kcore_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = clog2(NUM_REQ),
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_empty_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout,
  output logic [NUM_REQ-1:0]            req_read,
  output logic                          proc_start,
  input  logic                          proc_ready,
  input  logic                          proc_done,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [DATA_WIDTH-1:0]         grant_data,
  output logic                          busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  perf_cnt
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] pick_data;
  logic                  pop;

  kernel_kcore_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (req_empty_n),
    .last   (last_grant),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the head token of the winning FIFO.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_data = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next state and strobes; the pop is suppressed while reset is asserted.
  always_comb begin
    state_d    = state_q;
    req_read   = '0;
    proc_start = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && ap_rst_n) begin
          pop      = 1'b1;
          req_read = pick_onehot;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        proc_start = 1'b1;
        if (proc_ready) state_d = proc_done ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (proc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // State and grant registers; last_grant resets so requester 0 wins first.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      grant_id   <= '0;
      grant_data <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        grant_id   <= pick_idx;
        grant_data <= pick_data;
        last_grant <= pick_idx;
      end
    end
  end

`ifdef KCORE_ARB_PERF_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] perf_q;

  // Saturating grant counters, one slice per requester.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      perf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_read[i] && (perf_q[i*CNT_WIDTH +: CNT_WIDTH] != '1))
          perf_q[i*CNT_WIDTH +: CNT_WIDTH] <= perf_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_kernel_kcore_start_arbiter.sv
// Directed bench for kernel_kcore_start_arbiter (4 requesters, 1-bit tokens,
// 2-bit perf counters). Honours KCORE_ARB_PERF_EN for the counter checks.
module tb_kernel_kcore_start_arbiter;

`ifdef KCORE_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic [3:0] req_empty_n;
  logic [3:0] req_dout;
  logic [3:0] req_read;
  logic       proc_start;
  logic       proc_ready;
  logic       proc_done;
  logic [1:0] grant_id;
  logic [0:0] grant_data;
  logic       busy;
  logic [7:0] perf_cnt;

  int         n_cmp;
  int         n_bad;
  logic [7:0] fbits [4];
  int         fcnt  [4];
  logic [3:0] seen_rd;

  kernel_kcore_start_arbiter #(
    .NUM_REQ    (4),
    .ID_WIDTH   (2),
    .DATA_WIDTH (1),
    .CNT_WIDTH  (2)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .req_empty_n (req_empty_n),
    .req_dout    (req_dout),
    .req_read    (req_read),
    .proc_start  (proc_start),
    .proc_ready  (proc_ready),
    .proc_done   (proc_done),
    .grant_id    (grant_id),
    .grant_data  (grant_data),
    .busy        (busy),
    .perf_cnt    (perf_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_empty_n[i] = (fcnt[i] != 0);
      req_dout[i]    = fbits[i][0];
    end
  endtask

  task automatic push(input int r, input logic b);
    fbits[r][fcnt[r]] = b;
    fcnt[r]++;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) begin
      fbits[i] = '0;
      fcnt[i]  = 0;
    end
  endtask

  task automatic to_neg();
    @(negedge ap_clk);
  endtask

  // Called at the negedge: checks the pop strobes, crosses the edge, pops the
  // FIFO model and re-drives the FIFO outputs.
  task automatic to_pos();
    logic [3:0] rd;
    rd = req_read;
    n_cmp++;
    if ((rd & ~req_empty_n) !== 4'b0000) begin
      n_bad++;
      $display("FAIL read_empty: req_read=%b req_empty_n=%b required no pop of empty", rd, req_empty_n);
    end
    n_cmp++;
    if ($countones(rd) > 1) begin
      n_bad++;
      $display("FAIL read_onehot: req_read=%b required at most one bit", rd);
    end
    seen_rd = seen_rd | rd;
    @(posedge ap_clk);
    for (int i = 0; i < 4; i++) begin
      if (rd[i] === 1'b1) begin
        fbits[i] = fbits[i] >> 1;
        fcnt[i]--;
      end
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    to_neg();
    to_pos();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) push(i, 1'b1);
    drive();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    for (int k = 0; k < 3; k++) begin
      to_pos();
      to_neg();
      n_cmp++;
      if (req_read !== 4'b0000) begin n_bad++; $display("FAIL reset_read: req_read=%b required 0000", req_read); end
      n_cmp++;
      if (proc_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: proc_start=%b required 0", proc_start); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: busy=%b required 0", busy); end
      n_cmp++;
      if (perf_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_perf: perf_cnt=%h required 00", perf_cnt); end
      n_cmp++;
      if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_gid: grant_id=%0d required 0", grant_id); end
    end
    clear_fifos();
    to_pos();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    push(2, 1'b1);
    drive();
    proc_ready = 1'b0;
    proc_done  = 1'b0;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0100) begin n_bad++; $display("FAIL single_pop: req_read=%b required 0100", req_read); end
    n_cmp++;
    if (proc_start !== 1'b0) begin n_bad++; $display("FAIL single_idle_start: proc_start=%b required 0", proc_start); end
    to_pos();
    to_neg();
    n_cmp++;
    if (proc_start !== 1'b1) begin n_bad++; $display("FAIL single_start1: proc_start=%b required 1", proc_start); end
    n_cmp++;
    if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_gid: grant_id=%0d required 2", grant_id); end
    n_cmp++;
    if (grant_data !== 1'b1) begin n_bad++; $display("FAIL single_gdata: grant_data=%b required 1", grant_data); end
    n_cmp++;
    if (req_read !== 4'b0000) begin n_bad++; $display("FAIL single_one_pop: req_read=%b required 0000", req_read); end
    to_pos();
    proc_ready = 1'b1;
    to_neg();
    n_cmp++;
    if (proc_start !== 1'b1) begin n_bad++; $display("FAIL single_start2: proc_start=%b required 1", proc_start); end
    to_pos();
    proc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      n_cmp++;
      if (proc_start !== 1'b0) begin n_bad++; $display("FAIL single_run_start: proc_start=%b required 0", proc_start); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL single_run_busy: busy=%b required 1", busy); end
      to_pos();
    end
    proc_done = 1'b1;
    to_neg();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_done_busy: busy=%b required 1", busy); end
    to_pos();
    proc_done = 1'b0;
    to_neg();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_after_busy: busy=%b required 0", busy); end
    n_cmp++;
    if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_gid_hold: grant_id=%0d required 2", grant_id); end
    to_pos();
  endtask

  task automatic test_fairness();
    logic [1:0] tok [4];
    logic [3:0] exp_rd;
    logic       expd;
    int         w;
    tok[0] = 2'b01; tok[1] = 2'b10; tok[2] = 2'b11; tok[3] = 2'b00;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push(r, tok[r][0]);
      push(r, tok[r][1]);
    end
    drive();
    proc_ready = 1'b1;
    proc_done  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w      = k % 4;
      exp_rd = 4'b0001 << w;
      expd   = tok[w][k/4];
      to_neg();
      n_cmp++;
      if (req_read !== exp_rd) begin n_bad++; $display("FAIL fair_pop%0d: req_read=%b required %b", k, req_read, exp_rd); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL fair_idle%0d: busy=%b required 0", k, busy); end
      to_pos();
      to_neg();
      n_cmp++;
      if (grant_id !== 2'(w)) begin n_bad++; $display("FAIL fair_gid%0d: grant_id=%0d required %0d", k, grant_id, w); end
      n_cmp++;
      if (grant_data !== expd) begin n_bad++; $display("FAIL fair_gdata%0d: grant_data=%b required %b", k, grant_data, expd); end
      n_cmp++;
      if (proc_start !== 1'b1) begin n_bad++; $display("FAIL fair_start%0d: proc_start=%b required 1", k, proc_start); end
      to_pos();
    end
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0000) begin n_bad++; $display("FAIL fair_drained: req_read=%b required 0000", req_read); end
    to_pos();
    proc_ready = 1'b0;
    proc_done  = 1'b0;
  endtask

  task automatic test_empty_gap();
    seen_rd = '0;
    push(1, 1'b1);
    drive();
    proc_ready = 1'b1;
    proc_done  = 1'b0;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0010) begin n_bad++; $display("FAIL gap_pop1: req_read=%b required 0010", req_read); end
    to_pos();
    to_neg();
    n_cmp++;
    if (grant_id !== 2'd1) begin n_bad++; $display("FAIL gap_gid1: grant_id=%0d required 1", grant_id); end
    to_pos();
    push(3, 1'b1);
    drive();
    proc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      n_cmp++;
      if (req_read !== 4'b0000) begin n_bad++; $display("FAIL gap_run_pop%0d: req_read=%b required 0000", k, req_read); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL gap_run_busy%0d: busy=%b required 1", k, busy); end
      to_pos();
    end
    proc_done = 1'b1;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0000) begin n_bad++; $display("FAIL gap_done_pop: req_read=%b required 0000", req_read); end
    to_pos();
    proc_done = 1'b0;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b1000) begin n_bad++; $display("FAIL gap_pop3: req_read=%b required 1000", req_read); end
    to_pos();
    proc_ready = 1'b1;
    proc_done  = 1'b1;
    to_neg();
    n_cmp++;
    if (grant_id !== 2'd3) begin n_bad++; $display("FAIL gap_gid3: grant_id=%0d required 3", grant_id); end
    to_pos();
    proc_ready = 1'b0;
    proc_done  = 1'b0;
    to_neg();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_end_busy: busy=%b required 0", busy); end
    n_cmp++;
    if (seen_rd !== 4'b1010) begin n_bad++; $display("FAIL gap_pulsed: pulsed=%b required 1010", seen_rd); end
    to_pos();
  endtask

  task automatic test_reset_mid();
    push(1, 1'b0);
    drive();
    proc_ready = 1'b1;
    proc_done  = 1'b0;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0010) begin n_bad++; $display("FAIL mid_pop1: req_read=%b required 0010", req_read); end
    to_pos();
    to_neg();
    to_pos();
    proc_ready = 1'b0;
    push(0, 1'b1);
    push(2, 1'b1);
    drive();
    to_neg();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_run_busy: busy=%b required 1", busy); end
    to_pos();
    ap_rst_n = 1'b0;
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_pop: req_read=%b required 0000", req_read); end
    to_pos();
    ap_rst_n = 1'b1;
    to_neg();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle_busy: busy=%b required 0", busy); end
    n_cmp++;
    if (proc_start !== 1'b0) begin n_bad++; $display("FAIL mid_idle_start: proc_start=%b required 0", proc_start); end
    n_cmp++;
    if (req_read !== 4'b0001) begin n_bad++; $display("FAIL mid_pop0: req_read=%b required 0001", req_read); end
    to_pos();
    proc_ready = 1'b1;
    proc_done  = 1'b1;
    to_neg();
    n_cmp++;
    if (grant_id !== 2'd0) begin n_bad++; $display("FAIL mid_gid0: grant_id=%0d required 0", grant_id); end
    n_cmp++;
    if (grant_data !== 1'b1) begin n_bad++; $display("FAIL mid_gdata0: grant_data=%b required 1", grant_data); end
    to_pos();
    to_neg();
    n_cmp++;
    if (req_read !== 4'b0100) begin n_bad++; $display("FAIL mid_pop2: req_read=%b required 0100", req_read); end
    to_pos();
    to_neg();
    n_cmp++;
    if (grant_id !== 2'd2) begin n_bad++; $display("FAIL mid_gid2: grant_id=%0d required 2", grant_id); end
    to_pos();
    proc_ready = 1'b0;
    proc_done  = 1'b0;
    to_neg();
    to_pos();
  endtask

  task automatic test_perf();
    logic [1:0] exp_cnt;
    do_reset();
    for (int k = 0; k < 5; k++) push(0, k[0]);
    drive();
    proc_ready = 1'b1;
    proc_done  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = PERF ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
      to_neg();
      n_cmp++;
      if (req_read !== 4'b0001) begin n_bad++; $display("FAIL perf_pop%0d: req_read=%b required 0001", k, req_read); end
      to_pos();
      to_neg();
      n_cmp++;
      if (perf_cnt[1:0] !== exp_cnt) begin n_bad++; $display("FAIL perf_cnt0_%0d: perf_cnt[0]=%0d required %0d", k, perf_cnt[1:0], exp_cnt); end
      n_cmp++;
      if (perf_cnt[7:2] !== 6'd0) begin n_bad++; $display("FAIL perf_others_%0d: perf_cnt[3:1]=%h required 0", k, perf_cnt[7:2]); end
      to_pos();
    end
    proc_ready = 1'b0;
    proc_done  = 1'b0;
    to_neg();
    to_pos();
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    seen_rd     = '0;
    ap_rst_n    = 1'b0;
    proc_ready  = 1'b0;
    proc_done   = 1'b0;
    clear_fifos();
    drive();
    test_reset();
    test_single();
    test_fairness();
    test_empty_gap();
    test_reset_mid();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
